bcd_7seg_scanner: RTL and testbench
===================================

// Module: bcd_7seg_scanner
// PURPOSE
//   Consumes packed 4-bit BCD digits from the BCD counter chain and drives a
//   time-multiplexed 7-segment display: one digit lit per refresh slot.
//   Sits directly downstream of the BCD counter(s), feeding board pins.
//   Tear-free: new digits are held in a shadow register and applied only at a frame boundary.
// PARAMETERS
//   NUM_DIGITS   4      number of display digits (1..8); digit 0 = least significant, rightmost
//   REFRESH_DIV  50000  clk cycles each digit stays lit (>=2)
//   ACTIVE_LOW   1      1: seg/dp/an outputs active-low (common anode); 0: active-high
// PORTS
//   clk          in   1             system clock, rising edge
//   reset        in   1             asynchronous, active-low reset
//   din          in   4*NUM_DIGITS  packed BCD, digit i = din[4i+3:4i]
//   dp_in        in   NUM_DIGITS    decimal point request per digit
//   load         in   1             1-cycle strobe: capture din/dp_in into shadow
//   seg          out  7             {g,f,e,d,c,b,a}, registered
//   dp           out  1             decimal point of lit digit, registered
//   an           out  NUM_DIGITS    one-hot digit enable, registered
//   upd_pending  out  1             shadow holds data not yet displayed
//   frame_tick   out  1             1-cycle pulse when digit index wraps to 0
// BEHAVIOUR
//   Reset (reset=0, async): prescaler=0, idx=0, shadow/display regs=0, upd_pending=0,
//     frame_tick=0, seg/dp/an all OFF (all 1s if ACTIVE_LOW, all 0s otherwise).
//   Prescaler: counts 0..REFRESH_DIV-1; at terminal count wraps to 0 and idx advances.
//   idx: 0,1,..,NUM_DIGITS-1,0 ... ; wrap from NUM_DIGITS-1 to 0 = frame boundary.
//   frame_tick: high for exactly the cycle after idx wraps to 0.
//   Outputs: seg/dp/an reflect idx one cycle after idx changes (registered decode).
//     an[idx] ON, all other an OFF; dp = display dp bit of idx.
//   Decode 0..9 standard (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F, active-high
//     {g..a}); codes 10..15 invalid -> dash (g only, 7'h40). ACTIVE_LOW inverts seg/dp/an.
//   Handshake: load=1 copies din/dp_in to shadow, sets upd_pending. At frame boundary,
//     if upd_pending: shadow -> display regs, upd_pending cleared. No backpressure;
//     multiple loads in one frame: last wins.
//   Simultaneous load and frame boundary: din/dp_in go straight to display regs,
//     upd_pending stays 0.
//   Reset mid-frame: everything returns to reset values immediately; pending shadow lost.
//   No ghosting blank slot; an and seg change on the same edge.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: display digits NUM_DIGITS-1 down to 1 that are 0
//     and above the most significant non-zero digit are blanked (seg OFF, an still
//     cycles, dp still honoured); digit 0 always shown.
//   Not defined: every digit decoded as-is, zeros shown as "0".
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1)
//   1 reset=0 mid-run -> seg=7'h7F, dp=1, an=4'hF, upd_pending=0 immediately, no clk needed.
//   2 release reset, no load -> an cycles E,D,B,7 every 4 clk; seg=7'h40 (digit "0") each
//     slot; frame_tick pulses once per 16 clk.
//   3 load din=16'h1234 mid-frame -> upd_pending=1 until next wrap; next frame
//     an=E seg=~7'h66, an=D seg=~7'h4F, an=B seg=~7'h5B, an=7 seg=~7'h06.
//   4 load 16'h00A5 -> digit1 shows dash (seg=~7'h40); with LEADING_ZERO_BLANK_EN
//     digits 3,2 seg=7'h7F, otherwise seg=~7'h3F.
//   5 load 16'h9999 in the wrap cycle -> displayed in the frame starting at that wrap,
//     upd_pending never asserts.
//   6 two loads (16'h1111 then 16'h2222) within one frame, dp_in=4'b0010 -> next frame
//     shows 2222, dp=0 only while an=D.

Source files
------------

// File: rtl/bcd_7seg_scanner.sv
// Time-multiplexed BCD to 7-segment scanner with tear-free shadow loading.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_7seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [4*NUM_DIGITS-1:0]   din_i,
    input  logic [NUM_DIGITS-1:0]     dp_in_i,
    input  logic                      load_i,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      upd_pending_o,
    output logic                      frame_tick_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    pend_q, pend_d;
    logic                    frame_tick_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   an_on;
    logic [6:0]              seg_raw;

    function automatic logic [6:0] bcd_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    // Scan timing and shadow/display handoff at the frame boundary.
    always_comb begin
        tick        = (pre_q == PRE_LAST);
        wrap        = tick && (idx_q == IDX_LAST);
        pre_d       = tick ? '0 : pre_q + PRE_W'(1);
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        if (load_i) begin
            shadow_d    = din_i;
            shadow_dp_d = dp_in_i;
        end
        if (wrap) begin
            if (load_i) begin
                disp_d    = din_i;
                disp_dp_d = dp_in_i;
            end else if (pend_q) begin
                disp_d    = shadow_q;
                disp_dp_d = shadow_dp_q;
            end
            pend_d = 1'b0;
        end else if (load_i) begin
            pend_d = 1'b1;
        end
    end

    // A digit is blanked while every digit from the top down to it is zero.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic leading;
            leading = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (disp_q[4*i +: 4] != 4'd0) leading = 1'b0;
                blank[i] = leading;
            end
        end
`endif
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_on     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = disp_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = blank[i];
                an_on[i]  = 1'b1;
            end
        end
        seg_raw = cur_blank ? 7'h00 : bcd_glyph(cur_digit);
        seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
        dp_d    = cur_dp ^ ACTIVE_LOW;
        an_d    = ACTIVE_LOW ? ~an_on : an_on;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pre_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            pend_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= ACTIVE_LOW;
            an_q         <= AN_OFF;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            pend_q       <= pend_d;
            frame_tick_q <= wrap;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg_o         = seg_q;
    assign dp_o          = dp_q;
    assign an_o          = an_q;
    assign upd_pending_o = pend_q;
    assign frame_tick_o  = frame_tick_q;

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Self-checking bench for bcd_7seg_scanner (4 digits, 4-cycle slots, active-low).
module tb_bcd_7seg_scanner;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] din   = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pend;
    logic        ft;

    int checks   = 0;
    int failures = 0;

    bcd_7seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk), .reset_ni(rst_n), .din_i(din), .dp_in_i(dp_in), .load_i(load),
        .seg_o(seg), .dp_o(dp), .an_o(an), .upd_pending_o(pend), .frame_tick_o(ft)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the scan is pure arithmetic on the edge count.
    int          m_e;
    int          m_slot;
    bit          m_wrap;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_dpd, m_dps;
    logic        m_pend;
    logic [6:0]  x_seg;
    logic [3:0]  x_an;
    logic        x_dp, x_ft;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v > 4'd9) return 7'h40;
        return t[v];
    endfunction

    function automatic bit blanked(input logic [15:0] d, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
        int top = 0;
        for (int i = 0; i < N; i++) if (d[4*i +: 4] != 4'd0) top = i;
        return slot > top;
`else
        return (d[0] & 1'b0) || (slot < 0);
`endif
    endfunction

    task automatic model_reset();
        m_e = 0; m_disp = '0; m_shadow = '0; m_dpd = '0; m_dps = '0; m_pend = 1'b0;
        x_seg = 7'h7F; x_an = 4'hF; x_dp = 1'b1; x_ft = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_slot = (m_e / DIV) % N;
                x_seg  = blanked(m_disp, m_slot) ? 7'h7F : ~glyph(m_disp[4*m_slot +: 4]);
                x_an   = ~(4'b0001 << m_slot);
                x_dp   = ~m_dpd[m_slot];
                m_e    = m_e + 1;
                m_wrap = (m_e % FRAME) == 0;
                x_ft   = m_wrap;
                if (load) begin
                    if (m_wrap) begin
                        m_disp = din; m_dpd = dp_in; m_pend = 1'b0;
                    end else begin
                        m_shadow = din; m_dps = dp_in; m_pend = 1'b1;
                    end
                end else if (m_wrap && m_pend) begin
                    m_disp = m_shadow; m_dpd = m_dps; m_pend = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cyc_seg",  32'(seg),  32'(x_seg));
                chk("cyc_an",   32'(an),   32'(x_an));
                chk("cyc_dp",   32'(dp),   32'(x_dp));
                chk("cyc_pend", 32'(pend), 32'(m_pend));
                chk("cyc_ft",   32'(ft),   32'(x_ft));
            end
        end
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        load = 1'b1; din = d; dp_in = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ft();
        bit seen = 1'b0;
        for (int i = 0; i < 2*FRAME + 4; i++) begin
            @(negedge clk);
            if (ft) begin seen = 1'b1; break; end
        end
        if (!seen) chk("ft_timeout", 32'(0), 32'(1));
    endtask

    // Waits for the next frame tick, then checks the four slots of the new frame.
    task automatic check_frame(input string name, input logic [6:0] s [4], input logic [3:0] dpx);
        logic [3:0] an_x [4];
        an_x = '{4'hE, 4'hD, 4'hB, 4'h7};
        wait_ft();
        for (int i = 0; i < N; i++) begin
            repeat ((i == 0) ? 1 : DIV) @(negedge clk);
            chk({name, "_an"},  32'(an),  32'(an_x[i]));
            chk({name, "_seg"}, 32'(seg), 32'(s[i]));
            chk({name, "_dp"},  32'(dp),  32'(dpx[i]));
        end
    endtask

    initial begin
        logic [6:0] f1234 [4];
        logic [6:0] f00a5 [4];
        logic [6:0] fzero [4];
        logic [6:0] f2222 [4];
        int nft;
        f1234 = '{7'h19, 7'h30, 7'h24, 7'h79};
        f2222 = '{7'h24, 7'h24, 7'h24, 7'h24};
`ifdef LEADING_ZERO_BLANK_EN
        f00a5 = '{7'h12, 7'h3F, 7'h7F, 7'h7F};
        fzero = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
        f00a5 = '{7'h12, 7'h3F, 7'h40, 7'h40};
        fzero = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif

        repeat (3) @(negedge clk);
        chk("rst_seg",  32'(seg),  32'(7'h7F));
        chk("rst_an",   32'(an),   32'(4'hF));
        chk("rst_dp",   32'(dp),   32'(1));
        chk("rst_pend", 32'(pend), 32'(0));
        chk("rst_ft",   32'(ft),   32'(0));
        rst_n = 1'b1;

        @(negedge clk);
        chk("first_an",  32'(an),  32'(4'hE));
        chk("first_seg", 32'(seg), 32'(7'h40));
        nft = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (ft) nft++;
        end
        chk("ft_per_32", 32'(nft), 32'(2));

        do_load(16'h1234, 4'h0);
        chk("pend_after_load", 32'(pend), 32'(1));
        check_frame("f1234", f1234, 4'hF);
        chk("pend_cleared", 32'(pend), 32'(0));

        do_load(16'h00A5, 4'h0);
        check_frame("f00a5", f00a5, 4'hF);

        wait_ft();
        repeat (FRAME - 1) @(negedge clk);
        do_load(16'h9999, 4'h0);
        chk("wrap_load_ft",   32'(ft),   32'(1));
        chk("wrap_load_pend", 32'(pend), 32'(0));
        @(negedge clk);
        chk("wrap_load_an",  32'(an),  32'(4'hE));
        chk("wrap_load_seg", 32'(seg), 32'(7'h10));

        do_load(16'h1111, 4'b0010);
        @(negedge clk);
        do_load(16'h2222, 4'b0010);
        chk("two_load_pend", 32'(pend), 32'(1));
        check_frame("f2222", f2222, 4'b1101);

        repeat (400) begin
            load  = ($urandom_range(0, 5) == 0);
            din   = 16'($urandom);
            dp_in = 4'($urandom);
            @(negedge clk);
        end
        load = 1'b0;

        wait_ft();
        repeat (3) @(negedge clk);
        do_load(16'h8765, 4'hF);
        chk("pre_rst_pend", 32'(pend), 32'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_seg",  32'(seg),  32'(7'h7F));
        chk("midrst_an",   32'(an),   32'(4'hF));
        chk("midrst_dp",   32'(dp),   32'(1));
        chk("midrst_pend", 32'(pend), 32'(0));
        chk("midrst_ft",   32'(ft),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_an",  32'(an),  32'(4'hE));
        chk("post_rst_seg", 32'(seg), 32'(7'h40));
        check_frame("fzero", fzero, 4'hF);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
